// File: rtl/bel_fft_twiddle_gen_pkg.sv
// Shared definitions for the FFT twiddle generator: quadrant codes,
// one-hot select check and the quarter-wave table builder.
package bel_fft_twiddle_gen_pkg;

   // Quadrant of the requested angle (upper two bits of k mod N)
   typedef enum logic [1:0] {
      QD_0   = 2'd0,
      QD_90  = 2'd1,
      QD_180 = 2'd2,
      QD_270 = 2'd3
   } quad_e;

   // Fixed-point constants used by the table builder (Q30)
   localparam longint ONE_Q30 = 64'sd1 <<< 30;
   localparam longint PI_Q30  = 64'sd3373259426;

   // True when exactly one select bit is set
   function automatic logic is_onehot(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   // One quarter-wave component, cos or sin of 2*pi*r/2^log2n, rounded to
   // Q1.(ww-1) and clipped to [0, 2^(ww-1)-1]. Evaluated at elaboration only,
   // so integer Taylor series in Q30 stands in for a ROM image file.
   function automatic longint qtw_comp(input longint r, input int log2n,
                                       input int ww, input logic want_cos);
      longint x, term, sum, lim;
      x    = (PI_Q30 * r) >>> (log2n - 1);
      term = want_cos ? ONE_Q30 : x;
      sum  = term;
      for (int n = 1; n <= 12; n++) begin
         term = (term * x) >>> 30;
         term = (term * x) >>> 30;
         if (want_cos) term = -(term / longint'((2*n - 1) * (2*n)));
         else          term = -(term / longint'((2*n) * (2*n + 1)));
         sum = sum + term;
      end
      sum = (sum + (ONE_Q30 >>> ww)) >>> (31 - ww);
      lim = (longint'(1) <<< (ww - 1)) - 1;
      if (sum > lim) sum = lim;
      if (sum < 0)   sum = 0;
      return sum;
   endfunction

endpackage

// File: rtl/bel_fft_twiddle_gen_qrom.sv
// Single-port synchronous quarter-wave ROM. Word r = {cos, sin} of 2*pi*r/N.
module bel_fft_twiddle_gen_qrom
   import bel_fft_twiddle_gen_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int AWIDTH = 6,
   parameter int LOG2N  = 8
) (
   input  logic              clock,
   input  logic              clken,
   input  logic [AWIDTH-1:0] address,
   output logic [WIDTH-1:0]  q
);

   localparam int HW = WIDTH / 2;

   logic [WIDTH-1:0] rom [2**AWIDTH];

   for (genvar a = 0; a < 2**AWIDTH; a++) begin : g_word
      localparam longint C = qtw_comp(longint'(a), LOG2N, HW, 1'b1);
      localparam longint S = qtw_comp(longint'(a), LOG2N, HW, 1'b0);
      assign rom[a] = {C[HW-1:0], S[HW-1:0]};
   end

   // Registered read, held while clken is low
   always_ff @(posedge clock) begin
      if (clken) q <= rom[address];
   end

endmodule

// File: rtl/bel_fft_twiddle_gen.sv
// Multi-configuration FFT twiddle generator: W_N^k = cos - j*sin from a
// per-config quarter-wave ROM, folded to the full circle. Three stages
// (input reg, ROM read, fold/output reg) with a global stall enable.
module bel_fft_twiddle_gen
   import bel_fft_twiddle_gen_pkg::*;
#(
   parameter int          WORD_WIDTH  = 16,
   parameter int          CONFIG_NUM  = 2,
   parameter int          MAX_AWIDTH  = 10,
   parameter logic [31:0] CFG_AWIDTHS = 32'h0A_09_08_06
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [CONFIG_NUM-1:0]   cfg_sel_i,
   input  logic [MAX_AWIDTH-1:0]   adr_i,
   input  logic                    rd_i,
   output logic                    rdy_o,
   output logic [2*WORD_WIDTH-1:0] dat_o,
   output logic                    vld_o,
   input  logic                    ack_i,
   output logic                    cfg_err_o
);

   localparam int W  = WORD_WIDTH;
   localparam int IW = MAX_AWIDTH - 2;
   localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

   // Negation that maps the most negative code to the most positive one
   function automatic logic [W-1:0] sneg(input logic [W-1:0] x);
      return (x == SAT_MIN) ? SAT_MAX : (~x + W'(1));
   endfunction

   logic                         en;
   logic [2:0]                   vld_pipe_q;   // [0] S0, [1] S1, [2] S2 = vld_o
   logic [CONFIG_NUM-1:0]        s0_cfg_q, s1_cfg_q;
   logic                         s0_err_q, s1_err_q, cfg_err_q, sel_err;
   quad_e                        quad_d, s0_quad_q, s1_quad_q;
   logic [IW-1:0]                s0_idx_q;
   logic [CONFIG_NUM-1:0][1:0]   cfg_quad;
   logic [CONFIG_NUM-1:0][2*W-1:0] rom_q;
   logic [2*W-1:0]               word_sel, fold_d, dat_q;
   logic [W-1:0]                 c_w, s_w;
   logic                         unused_adr;

   assign en        = !vld_pipe_q[2] | ack_i;
   assign rdy_o     = en;
   assign vld_o     = vld_pipe_q[2];
   assign dat_o     = dat_q;
   assign cfg_err_o = cfg_err_q;
   assign sel_err   = !is_onehot(4'(cfg_sel_i));
   // Index bits above a config's log2(N) are dropped, giving wrap mod N
   assign unused_adr = ^{adr_i, s0_idx_q};

   for (genvar i = 0; i < CONFIG_NUM; i++) begin : g_cfg
      localparam int A   = int'(CFG_AWIDTHS[8*i +: 8]);
      localparam int RAW = (A > 2) ? A - 2 : 1;
      logic [RAW-1:0] rom_adr;
      assign cfg_quad[i] = adr_i[A-1 -: 2];
      if (A > 2) begin : g_adr
         assign rom_adr = s0_idx_q[RAW-1:0];
      end else begin : g_adr0
         assign rom_adr = '0;
      end
      bel_fft_twiddle_gen_qrom #(
         .WIDTH  (2*W),
         .AWIDTH (RAW),
         .LOG2N  (A)
      ) u_rom (
         .clock   (clk_i),
         .clken   (en & vld_pipe_q[0] & s0_cfg_q[i]),
         .address (rom_adr),
         .q       (rom_q[i])
      );
   end

   // Quadrant of the request, taken at the selected config's width
   always_comb begin
      quad_d = QD_0;
      for (int i = 0; i < CONFIG_NUM; i++)
         if (cfg_sel_i[i]) quad_d = quad_e'(quad_d | cfg_quad[i]);
   end

   // Valid shift register and sticky select-error flag
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         vld_pipe_q <= '0;
         cfg_err_q  <= 1'b0;
      end else if (en) begin
         vld_pipe_q <= {vld_pipe_q[1:0], rd_i};
         if (rd_i && sel_err) cfg_err_q <= 1'b1;
      end
   end

   // S0 input register and S1 side-band alongside the ROM read
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s0_cfg_q  <= '0;
         s0_err_q  <= 1'b0;
         s0_quad_q <= QD_0;
         s0_idx_q  <= '0;
         s1_cfg_q  <= '0;
         s1_err_q  <= 1'b0;
         s1_quad_q <= QD_0;
      end else if (en) begin
         s0_cfg_q  <= cfg_sel_i;
         s0_err_q  <= sel_err;
         s0_quad_q <= quad_d;
         s0_idx_q  <= adr_i[IW-1:0];
         s1_cfg_q  <= s0_cfg_q;
         s1_err_q  <= s0_err_q;
         s1_quad_q <= s0_quad_q;
      end
   end

   // ROM word picked by the config that travelled with the item
   always_comb begin
      word_sel = '0;
      for (int i = 0; i < CONFIG_NUM; i++)
         if (s1_cfg_q[i]) word_sel = word_sel | rom_q[i];
   end

   assign c_w = word_sel[2*W-1:W];
   assign s_w = word_sel[W-1:0];

   // Quadrant fold: rebuild cos - j*sin over the full circle
   always_comb begin
      fold_d = '0;
      case (s1_quad_q)
         QD_0:    fold_d = {c_w, sneg(s_w)};
         QD_90:   fold_d = {sneg(s_w), sneg(c_w)};
         QD_180:  fold_d = {sneg(c_w), s_w};
         default: fold_d = {s_w, c_w};
      endcase
      if (s1_err_q) fold_d = '0;
   end

   // S2 output register, loaded only by real items
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                   dat_q <= '0;
      else if (en && vld_pipe_q[1]) dat_q <= fold_d;
   end

endmodule

// File: tb/tb_bel_fft_twiddle_gen.sv
// Directed + randomized bench for bel_fft_twiddle_gen (N=64 / N=256 configs).
module tb_bel_fft_twiddle_gen;

   logic        clk = 1'b0;
   logic        rst_i;
   logic [1:0]  cfg_sel_i;
   logic [9:0]  adr_i;
   logic        rd_i;
   logic        rdy_o;
   logic [31:0] dat_o;
   logic        vld_o;
   logic        ack_i;
   logic        cfg_err_o;

   int checks   = 0;
   int failures = 0;

   bel_fft_twiddle_gen dut (
      .clk_i     (clk),
      .rst_i     (rst_i),
      .cfg_sel_i (cfg_sel_i),
      .adr_i     (adr_i),
      .rd_i      (rd_i),
      .rdy_o     (rdy_o),
      .dat_o     (dat_o),
      .vld_o     (vld_o),
      .ack_i     (ack_i),
      .cfg_err_o (cfg_err_o)
   );

   always #5 clk = ~clk;

   // Q1.15 rounding of a real value, symmetric and clipped to +/-32767
   function automatic logic [15:0] q15(input real v);
      real y;
      int  r;
      y = v * 32768.0;
      if (y >= 0.0) r = $rtoi($floor(y + 0.5));
      else          r = -$rtoi($floor(-y + 0.5));
      if (r > 32767)  r = 32767;
      if (r < -32767) r = -32767;
      return 16'(r);
   endfunction

   // Reference twiddle straight from the definition W_N^k = e^(-j*2*pi*k/N)
   function automatic logic [31:0] model_tw(input int k, input int log2n);
      int  n, kk;
      real ang;
      n   = 1 << log2n;
      kk  = k % n;
      ang = 2.0 * 3.14159265358979323846 * real'(kk) / real'(n);
      return {q15($cos(ang)), q15(-$sin(ang))};
   endfunction

   function automatic int log2n_of(input logic [1:0] sel);
      return (sel == 2'b01) ? 6 : 8;
   endfunction

   function automatic logic close1(input logic [31:0] a, input logic [31:0] b);
      int dr, di;
      dr = int'($signed(a[31:16])) - int'($signed(b[31:16]));
      di = int'($signed(a[15:0]))  - int'($signed(b[15:0]));
      return (dr >= -1) && (dr <= 1) && (di >= -1) && (di <= 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1ns later
   task automatic drive(input logic rd, input logic [1:0] sel, input logic [9:0] adr,
                        input logic ack);
      @(negedge clk);
      rd_i = rd; cfg_sel_i = sel; adr_i = adr; ack_i = ack;
      #1;
   endtask

   // One isolated request: vld_o rises on the third edge after acceptance
   task automatic single(input string tag, input logic [1:0] sel, input logic [9:0] adr,
                         input logic [31:0] exp);
      drive(1'b1, sel, adr, 1'b1);
      chk({tag, " rdy"}, 32'(rdy_o), 32'd1);
      drive(1'b0, 2'b01, 10'd0, 1'b1);
      chk({tag, " vld+1"}, 32'(vld_o), 32'd0);
      drive(1'b0, 2'b01, 10'd0, 1'b1);
      chk({tag, " vld+2"}, 32'(vld_o), 32'd0);
      drive(1'b0, 2'b01, 10'd0, 1'b1);
      chk({tag, " vld+3"}, 32'(vld_o), 32'd1);
      chk({tag, " dat"}, dat_o, exp);
   endtask

   logic [31:0] sbq[$];
   logic [31:0] exp_w;
   logic        r_rd, r_ack;
   logic [1:0]  r_sel;
   logic [9:0]  r_adr;
   int          unexpected;

   initial begin
      rst_i = 1'b1; rd_i = 1'b0; cfg_sel_i = 2'b01; adr_i = '0; ack_i = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset vld", 32'(vld_o), 32'd0);
      chk("reset dat", dat_o, 32'd0);
      chk("reset err", 32'(cfg_err_o), 32'd0);
      chk("reset rdy", 32'(rdy_o), 32'd1);
      @(negedge clk);
      rst_i = 1'b0;

      // cardinal points, N=64
      single("k0",  2'b01, 10'd0,  32'h7FFF_0000);
      single("k16", 2'b01, 10'd16, 32'h0000_8001);
      single("k32", 2'b01, 10'd32, 32'h8001_0000);
      single("k48", 2'b01, 10'd48, 32'h0000_7FFF);

      // interleaved configs back to back
      drive(1'b1, 2'b01, 10'd8,  1'b1);
      drive(1'b1, 2'b10, 10'd32, 1'b1);
      drive(1'b1, 2'b01, 10'd8,  1'b1);
      chk("ilv none yet", 32'(vld_o), 32'd0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 2'b01, 10'd0, 1'b1);
         chk($sformatf("ilv vld%0d", i), 32'(vld_o), 32'd1);
         chk($sformatf("ilv dat%0d", i), dat_o, 32'h5A82_A57E);
      end
      drive(1'b0, 2'b01, 10'd0, 1'b1);
      chk("ilv end", 32'(vld_o), 32'd0);

      // backpressure: three in flight, then four stalled cycles
      drive(1'b1, 2'b01, 10'd0,  1'b1);
      drive(1'b1, 2'b10, 10'd64, 1'b1);
      drive(1'b1, 2'b01, 10'd48, 1'b1);
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 2'b01, 10'd5, 1'b0);
         chk($sformatf("bp rdy%0d", i), 32'(rdy_o), 32'd0);
         chk($sformatf("bp vld%0d", i), 32'(vld_o), 32'd1);
         chk($sformatf("bp hold%0d", i), dat_o, 32'h7FFF_0000);
      end
      drive(1'b0, 2'b01, 10'd0, 1'b1);
      chk("bp out0", dat_o, 32'h7FFF_0000);
      drive(1'b0, 2'b01, 10'd0, 1'b1);
      chk("bp out1", dat_o, 32'h0000_8001);
      chk("bp vld1", 32'(vld_o), 32'd1);
      drive(1'b0, 2'b01, 10'd0, 1'b1);
      chk("bp out2", dat_o, 32'h0000_7FFF);
      chk("bp vld2", 32'(vld_o), 32'd1);
      drive(1'b0, 2'b01, 10'd0, 1'b1);
      chk("bp drained", 32'(vld_o), 32'd0);

      // wrap-around modulo N
      single("wrap80", 2'b01, 10'd80, 32'h0000_8001);

      // randomized traffic against the reference with a scoreboard
      unexpected = 0;
      for (int c = 0; c < 400; c++) begin
         r_rd  = ($urandom_range(0, 9) < 7);
         r_ack = ($urandom_range(0, 9) < 7);
         r_sel = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
         r_adr = 10'($urandom);
         drive(r_rd, r_sel, r_adr, r_ack);
         if (vld_o && ack_i) begin
            if (sbq.size() == 0) unexpected++;
            else begin
               exp_w = sbq.pop_front();
               checks++;
               assert (close1(dat_o, exp_w)) else begin
                  failures++;
                  $error("FAIL rand dat: got %h expected %h", dat_o, exp_w);
               end
            end
         end
         if (rd_i && rdy_o) sbq.push_back(model_tw(int'(r_adr), log2n_of(r_sel)));
      end
      for (int c = 0; c < 10; c++) begin
         drive(1'b0, 2'b01, 10'd0, 1'b1);
         if (vld_o) begin
            if (sbq.size() == 0) unexpected++;
            else begin
               exp_w = sbq.pop_front();
               checks++;
               assert (close1(dat_o, exp_w)) else begin
                  failures++;
                  $error("FAIL rand drain: got %h expected %h", dat_o, exp_w);
               end
            end
         end
      end
      chk("rand leftover", 32'(sbq.size()), 32'd0);
      chk("rand unexpected", 32'(unexpected), 32'd0);

      // invalid selects: zeroed data, sticky error
      chk("err clear", 32'(cfg_err_o), 32'd0);
      drive(1'b1, 2'b11, 10'd5, 1'b1);
      drive(1'b0, 2'b01, 10'd0, 1'b1);
      chk("err set", 32'(cfg_err_o), 32'd1);
      drive(1'b0, 2'b01, 10'd0, 1'b1);
      drive(1'b0, 2'b01, 10'd0, 1'b1);
      chk("err vld", 32'(vld_o), 32'd1);
      chk("err dat", dat_o, 32'd0);
      single("sel00", 2'b00, 10'd7, 32'd0);
      single("after err", 2'b10, 10'd64, 32'h0000_8001);
      chk("err sticky", 32'(cfg_err_o), 32'd1);

      // reset with three items in flight
      drive(1'b1, 2'b01, 10'd0,  1'b1);
      drive(1'b1, 2'b01, 10'd16, 1'b1);
      drive(1'b1, 2'b01, 10'd32, 1'b1);
      @(negedge clk);
      rd_i = 1'b0;
      rst_i = 1'b1;
      #1;
      chk("rst vld", 32'(vld_o), 32'd0);
      chk("rst dat", dat_o, 32'd0);
      chk("rst err", 32'(cfg_err_o), 32'd0);
      @(negedge clk);
      rst_i = 1'b0;
      unexpected = 0;
      for (int c = 0; c < 6; c++) begin
         drive(1'b0, 2'b01, 10'd0, 1'b1);
         if (vld_o) unexpected++;
      end
      chk("rst no ghosts", 32'(unexpected), 32'd0);
      single("post rst", 2'b01, 10'd48, 32'h0000_7FFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
